// File: rtl/stage_maxpool_mc.sv
// stage_maxpool_mc
// 2x2 / stride-2 max pooling over a raster-ordered feature map with CH
// channels packed side by side in each beat. The horizontal pair maximum
// of an even row is parked in a half-width line buffer. It is combined
// with the horizontal pair maximum of the following odd row, which yields
// one pooled pixel per 2x2 window. The result is registered, so each output
// pulse appears one cycle after the window's bottom-right beat.
module stage_maxpool_mc #(
  parameter int IBW    = 19,
  parameter int COL    = 24,
  parameter int ROW    = 24,
  parameter int CH     = 1,
  parameter int SIGNED = 0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_clear,
  input  logic              i_in_valid,
  input  logic [CH*IBW-1:0] i_in_fmap,
  output logic              o_ot_valid,
  output logic [CH*IBW-1:0] o_ot_fmap,
  output logic              o_ot_last
);

  localparam int DW   = CH * IBW;
  localparam int CW   = (COL > 1) ? $clog2(COL) : 1;
  localparam int RW   = (ROW > 1) ? $clog2(ROW) : 1;
  localparam int HALF = (COL / 2 > 0) ? COL / 2 : 1;
  localparam int LBW  = (HALF > 1) ? $clog2(HALF) : 1;

  // Geometry sanity: windows must tile the frame exactly.
  generate
    if (((COL % 2) != 0) || (COL < 2)) begin : g_bad_col
      $error("stage_maxpool_mc: COL must be even and >= 2");
    end
    if (((ROW % 2) != 0) || (ROW < 2)) begin : g_bad_row
      $error("stage_maxpool_mc: ROW must be even and >= 2");
    end
    if ((SIGNED != 0) && (SIGNED != 1)) begin : g_bad_signed
      $error("stage_maxpool_mc: SIGNED must be 0 or 1");
    end
  endgenerate

  // Full-width maximum. Ties return b, which equals a, so the result does
  // not depend on the tie choice.
  function automatic logic [IBW-1:0] max_f(input logic [IBW-1:0] a,
                                           input logic [IBW-1:0] b);
    logic a_gt;
    if (SIGNED != 0) begin
      a_gt = ($signed(a) > $signed(b));
    end else begin
      a_gt = (a > b);
    end
    return a_gt ? a : b;
  endfunction

  // Position counters
  logic [CW-1:0] col_reg, col_next;
  logic [RW-1:0] row_reg, row_next;

  // Datapath storage. The hold register and the line buffer are not reset:
  // each entry is always written before it is read for a window.
  logic [DW-1:0] hold_reg;
  logic [DW-1:0] lbuf_mem [HALF];
  logic [DW-1:0] lbuf_rd;
  logic [DW-1:0] hmax;
  logic [DW-1:0] vmax;
  logic [LBW-1:0] lb_addr;

  // Beat qualification. A beat that arrives together with i_clear is
  // dropped.
  logic accept;
  logic col_odd, row_odd;
  logic col_last, row_last;
  logic out_fire, out_last;

  assign accept   = i_in_valid & ~i_clear;
  assign col_odd  = col_reg[0];
  assign row_odd  = row_reg[0];
  assign col_last = (col_reg == CW'(COL - 1));
  assign row_last = (row_reg == RW'(ROW - 1));
  assign lb_addr  = LBW'(col_reg >> 1);
  assign lbuf_rd  = lbuf_mem[lb_addr];

  // A window completes on the bottom-right pixel (odd row, odd column).
  assign out_fire = accept & col_odd & row_odd;
  assign out_last = out_fire & col_last & row_last;

  // Per-channel compare trees: the horizontal pair, then vertical against
  // the stored pair.
  generate
    for (genvar gi = 0; gi < CH; gi++) begin : g_ch
      assign hmax[gi*IBW +: IBW] = max_f(hold_reg[gi*IBW +: IBW],
                                         i_in_fmap[gi*IBW +: IBW]);
      assign vmax[gi*IBW +: IBW] = max_f(lbuf_rd[gi*IBW +: IBW],
                                         hmax[gi*IBW +: IBW]);
    end
  endgenerate

  // Next-position logic. Counters advance only on valid beats. The column
  // wraps and carries into the row, and the row wraps at end of frame.
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (i_clear) begin
      col_next = '0;
      row_next = '0;
    end else if (i_in_valid) begin
      if (col_last) begin
        col_next = '0;
        row_next = row_last ? '0 : row_reg + RW'(1);
      end else begin
        col_next = col_reg + CW'(1);
      end
    end
  end

  // Position registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // Capture the left pixel of each horizontal pair.
  always_ff @(posedge clk) begin
    if (accept && !col_odd) begin
      hold_reg <= i_in_fmap;
    end
  end

  // Even rows store their pair maxima for the row below.
  always_ff @(posedge clk) begin
    if (accept && col_odd && !row_odd) begin
      lbuf_mem[lb_addr] <= hmax;
    end
  end

  // Output register. The data holds between pulses, and valid/last are
  // single-cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_ot_valid <= 1'b0;
      o_ot_last  <= 1'b0;
      o_ot_fmap  <= '0;
    end else if (i_clear) begin
      o_ot_valid <= 1'b0;
      o_ot_last  <= 1'b0;
    end else begin
      o_ot_valid <= out_fire;
      o_ot_last  <= out_last;
      if (out_fire) begin
        o_ot_fmap <= vmax;
      end
    end
  end

endmodule
